uart_frame_loader: RTL and testbench



---
 rtl/uart_frame_loader.sv | 179 +++++++++++++++++
 tb/tb_uart_frame_loader.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_loader.sv
// uart_frame_loader: parses a framed UART byte stream (header, RGB565 pixels,
// 8-bit checksum) into the back bank of a double-buffered pixel RAM. After a
// good checksum the displayed bank is swapped on the next vertical sync, so the
// scan-out never shows a partially written frame.
module uart_frame_loader #(
  parameter int         PIX_NUM     = 65536,
  parameter int         ADDR_W      = 16,
  parameter int         TIMEOUT_CYC = 5000000,
  parameter logic [7:0] HDR0        = 8'hA5,
  parameter logic [7:0] HDR1        = 8'h5A
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              vsync_pulse,
  output logic              ram_wren,
  output logic [ADDR_W:0]   ram_wraddr,
  output logic [15:0]       ram_wrdata,
  output logic              disp_bank,
  output logic              busy,
  output logic              frame_ok,
  output logic              frame_err,
  output logic              LED
);

  localparam int              TMO_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(PIX_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HDR       = 3'd1,
    S_PIX_HI    = 3'd2,
    S_PIX_LO    = 3'd3,
    S_CKSUM     = 3'd4,
    S_SWAP_WAIT = 3'd5
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   pix_cnt_q;
  logic [7:0]          cksum_q;
  logic [7:0]          hi_q;
  logic [TMO_W-1:0]    tmo_q;
  logic                wren_q;
  logic [ADDR_W:0]     wraddr_q;
  logic [15:0]         wrdata_q;
  logic                disp_bank_q;
  logic                busy_q;
  logic                frame_ok_q;
  logic                frame_err_q;
  logic                led_q;

  logic                timed_d;
  logic                tmo_expired_d;

  // Timeout is only armed while a frame is being received; a byte arriving on
  // the expiry cycle takes priority over the timeout.
  always_comb begin
    timed_d       = (state_q == S_HDR) || (state_q == S_PIX_HI) ||
                    (state_q == S_PIX_LO) || (state_q == S_CKSUM);
    tmo_expired_d = timed_d && !rx_done && (tmo_q == TMO_LAST);
  end

  // Frame parser FSM with registered outputs, timeout counter and bank swap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pix_cnt_q   <= '0;
      cksum_q     <= 8'h00;
      hi_q        <= 8'h00;
      tmo_q       <= '0;
      wren_q      <= 1'b0;
      wraddr_q    <= '0;
      wrdata_q    <= 16'h0000;
      disp_bank_q <= 1'b0;
      busy_q      <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      wren_q      <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;

      if (!timed_d || rx_done || tmo_expired_d) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TMO_W'(1);
      end

      if (tmo_expired_d) begin
        frame_err_q <= 1'b1;
        state_q     <= S_IDLE;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (rx_done && (rx_data == HDR0)) begin
              state_q <= S_HDR;
              busy_q  <= 1'b1;
            end
          end
          S_HDR: begin
            if (rx_done) begin
              if (rx_data == HDR1) begin
                pix_cnt_q <= '0;
                cksum_q   <= 8'h00;
                state_q   <= S_PIX_HI;
              end else if (rx_data == HDR0) begin
                state_q <= S_HDR;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
          S_PIX_HI: begin
            if (rx_done) begin
              hi_q    <= rx_data;
              cksum_q <= cksum_q + rx_data;
              state_q <= S_PIX_LO;
            end
          end
          S_PIX_LO: begin
            if (rx_done) begin
              cksum_q   <= cksum_q + rx_data;
              wren_q    <= 1'b1;
              wrdata_q  <= {hi_q, rx_data};
              wraddr_q  <= {~disp_bank_q, pix_cnt_q};
              // Natural wrap of the ADDR_W-bit counter keeps writes in-bank.
              pix_cnt_q <= pix_cnt_q + ADDR_W'(1);
              if (pix_cnt_q == PIX_LAST) begin
                state_q <= S_CKSUM;
              end else begin
                state_q <= S_PIX_HI;
              end
            end
          end
          S_CKSUM: begin
            if (rx_done) begin
              if (rx_data == cksum_q) begin
                state_q <= S_SWAP_WAIT;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
              end
            end
          end
          S_SWAP_WAIT: begin
            // Incoming bytes are dropped here; only vsync moves us on.
            if (vsync_pulse) begin
              disp_bank_q <= ~disp_bank_q;
              frame_ok_q  <= 1'b1;
              led_q       <= ~led_q;
              state_q     <= S_IDLE;
              busy_q      <= 1'b0;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ram_wren   = wren_q;
  assign ram_wraddr = wraddr_q;
  assign ram_wrdata = wrdata_q;
  assign disp_bank  = disp_bank_q;
  assign busy       = busy_q;
  assign frame_ok   = frame_ok_q;
  assign frame_err  = frame_err_q;
  assign LED        = led_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed testbench for uart_frame_loader with a reduced frame size
// (16 pixels) and a short inter-byte timeout (40 cycles).
module tb_uart_frame_loader;

  localparam int PIX_NUM = 16;
  localparam int ADDR_W  = 4;
  localparam int TMO     = 40;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_done;
  logic              vsync_pulse;
  logic              ram_wren;
  logic [ADDR_W:0]   ram_wraddr;
  logic [15:0]       ram_wrdata;
  logic              disp_bank;
  logic              busy;
  logic              frame_ok;
  logic              frame_err;
  logic              LED;

  int checks = 0;
  int errors = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  logic [ADDR_W:0] wa_q[$];
  logic [15:0]     wd_q[$];

  uart_frame_loader #(
    .PIX_NUM(PIX_NUM), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO),
    .HDR0(8'hA5), .HDR1(8'h5A)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .vsync_pulse(vsync_pulse), .ram_wren(ram_wren), .ram_wraddr(ram_wraddr),
    .ram_wrdata(ram_wrdata), .disp_bank(disp_bank), .busy(busy),
    .frame_ok(frame_ok), .frame_err(frame_err), .LED(LED)
  );

  always #5 clk = ~clk;

  // Log writes and count pulses (sampled on posedge, i.e. previous-cycle values).
  always @(posedge clk) begin
    if (ram_wren === 1'b1) begin
      wa_q.push_back(ram_wraddr);
      wd_q.push_back(ram_wrdata);
    end
    if (frame_ok === 1'b1) ok_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_pixels(input logic [7:0] hi, input logic [7:0] lo, input int n);
    for (int i = 0; i < n; i++) begin
      send_byte(hi);
      send_byte(lo);
    end
  endtask

  task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] ck);
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_pixels(hi, lo, PIX_NUM);
    send_byte(ck);
  endtask

  task automatic pulse_vsync();
    @(negedge clk);
    vsync_pulse = 1'b1;
    @(negedge clk);
    vsync_pulse = 1'b0;
  endtask

  task automatic settle_and_clear();
    repeat (2) @(negedge clk);
    wa_q.delete();
    wd_q.delete();
  endtask

  // Number of logged writes that deviate from a full frame of value d in bank.
  function automatic int count_bad(input logic bank, input logic [15:0] d);
    int bad = 0;
    if (wa_q.size() != PIX_NUM) bad++;
    for (int i = 0; i < wa_q.size(); i++) begin
      logic [ADDR_W:0] ea;
      ea = {bank, ADDR_W'(i)};
      if (wa_q[i] !== ea || wd_q[i] !== d) bad++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0; vsync_pulse = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ram_wren, ram_wraddr, ram_wrdata, disp_bank, busy, frame_ok, frame_err, LED} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got wren=%b addr=%h data=%h bank=%b busy=%b ok=%b err=%b led=%b, required all 0",
               ram_wren, ram_wraddr, ram_wrdata, disp_bank, busy, frame_ok, frame_err, LED);
    end
    rst = 1'b0;
    settle_and_clear();
  endtask

  // Scenario 1: good frame of 16'h1234, checksum 0x46*16 mod 256 = 0x60.
  task automatic test_good_frame();
    int ok0;
    ok0 = ok_cnt;
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_byte(8'h12);
    send_byte(8'h34);
    checks++;
    if (ram_wren !== 1'b1 || ram_wraddr !== 5'h10 || ram_wrdata !== 16'h1234) begin
      errors++;
      $display("FAIL first_write: got wren=%b addr=%h data=%h, required 1 10 1234", ram_wren, ram_wraddr, ram_wrdata);
    end
    send_pixels(8'h12, 8'h34, PIX_NUM - 1);
    send_byte(8'h60);
    checks++;
    if (busy !== 1'b1 || frame_err !== 1'b0 || disp_bank !== 1'b0) begin
      errors++;
      $display("FAIL good_swap_wait: got busy=%b err=%b bank=%b, required 1 0 0", busy, frame_err, disp_bank);
    end
    send_byte(8'hA5);
    repeat (3) @(negedge clk);
    checks++;
    if (disp_bank !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL good_hold: got bank=%b busy=%b, required 0 1", disp_bank, busy);
    end
    pulse_vsync();
    checks++;
    if (disp_bank !== 1'b1 || frame_ok !== 1'b1 || LED !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL good_swap: got bank=%b ok=%b led=%b busy=%b, required 1 1 1 0", disp_bank, frame_ok, LED, busy);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (count_bad(1'b1, 16'h1234) != 0 || ok_cnt - ok0 != 1) begin
      errors++;
      $display("FAIL good_writes: got %0d writes, %0d bad, %0d ok pulses, required 16 writes, 0 bad, 1 ok",
               wa_q.size(), count_bad(1'b1, 16'h1234), ok_cnt - ok0);
    end
    settle_and_clear();
  endtask

  // Scenario 5: second frame of 16'hABCD, checksum 0x178*16 mod 256 = 0x80, into bank 0.
  task automatic test_back_to_back();
    send_frame(8'hAB, 8'hCD, 8'h80);
    send_byte(8'h12);
    send_byte(8'h34);
    repeat (2) @(negedge clk);
    checks++;
    if (disp_bank !== 1'b1 || busy !== 1'b1 || wa_q.size() != PIX_NUM) begin
      errors++;
      $display("FAIL b2b_wait: got bank=%b busy=%b writes=%0d, required 1 1 16", disp_bank, busy, wa_q.size());
    end
    // Byte and vsync together: swap wins, byte is dropped.
    @(negedge clk);
    rx_data = 8'hA5; rx_done = 1'b1; vsync_pulse = 1'b1;
    @(negedge clk);
    rx_done = 1'b0; vsync_pulse = 1'b0;
    checks++;
    if (disp_bank !== 1'b0 || frame_ok !== 1'b1 || LED !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_swap: got bank=%b ok=%b led=%b busy=%b, required 0 1 0 0", disp_bank, frame_ok, LED, busy);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (count_bad(1'b0, 16'hABCD) != 0) begin
      errors++;
      $display("FAIL b2b_writes: got %0d writes, %0d bad, required 16 writes to bank 0, 0 bad",
               wa_q.size(), count_bad(1'b0, 16'hABCD));
    end
    settle_and_clear();
  endtask

  // Scenario 2: checksum off by one.
  task automatic test_bad_checksum();
    int ok0;
    int er0;
    ok0 = ok_cnt;
    er0 = err_cnt;
    send_frame(8'h12, 8'h34, 8'h61);
    checks++;
    if (frame_err !== 1'b1 || busy !== 1'b0 || disp_bank !== 1'b0) begin
      errors++;
      $display("FAIL bad_ck: got err=%b busy=%b bank=%b, required 1 0 0", frame_err, busy, disp_bank);
    end
    pulse_vsync();
    repeat (2) @(negedge clk);
    checks++;
    if (disp_bank !== 1'b0 || ok_cnt != ok0 || err_cnt - er0 != 1 || count_bad(1'b1, 16'h1234) != 0) begin
      errors++;
      $display("FAIL bad_ck_after: got bank=%b ok=%0d err=%0d writes=%0d, required 0 0 1 16",
               disp_bank, ok_cnt - ok0, err_cnt - er0, wa_q.size());
    end
    settle_and_clear();
  endtask

  // Scenario 3: byte on the expiry cycle wins; then silence produces the error.
  task automatic test_timeout();
    int early;
    early = 0;
    send_byte(8'hA5);
    send_byte(8'h5A);
    repeat (TMO - 2) @(negedge clk);
    send_byte(8'h12);
    checks++;
    if (frame_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_rx_wins: got err=%b busy=%b, required 0 1", frame_err, busy);
    end
    repeat (TMO - 1) begin
      @(negedge clk);
      if (frame_err !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL tmo_early: got %0d early err cycles, required 0", early);
    end
    @(negedge clk);
    checks++;
    if (frame_err !== 1'b1 || busy !== 1'b0 || disp_bank !== 1'b0) begin
      errors++;
      $display("FAIL tmo_err: got err=%b busy=%b bank=%b, required 1 0 0", frame_err, busy, disp_bank);
    end
    settle_and_clear();
    send_frame(8'h12, 8'h34, 8'h60);
    pulse_vsync();
    repeat (2) @(negedge clk);
    checks++;
    if (disp_bank !== 1'b1 || LED !== 1'b1 || count_bad(1'b1, 16'h1234) != 0) begin
      errors++;
      $display("FAIL tmo_recover: got bank=%b led=%b writes=%0d, required 1 1 16", disp_bank, LED, wa_q.size());
    end
    settle_and_clear();
  endtask

  // Scenario 4: repeated HDR0 is tolerated; a stray byte after HDR0 aborts.
  task automatic test_header();
    int er0;
    send_byte(8'hA5);
    send_frame(8'h12, 8'h34, 8'h60);
    pulse_vsync();
    repeat (2) @(negedge clk);
    checks++;
    if (disp_bank !== 1'b0 || LED !== 1'b0 || count_bad(1'b0, 16'h1234) != 0) begin
      errors++;
      $display("FAIL hdr_repeat: got bank=%b led=%b writes=%0d, required 0 0 16", disp_bank, LED, wa_q.size());
    end
    settle_and_clear();
    er0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h5A);
    send_pixels(8'h12, 8'h34, 2);
    repeat (2) @(negedge clk);
    checks++;
    if (wa_q.size() != 0 || busy !== 1'b0 || err_cnt != er0) begin
      errors++;
      $display("FAIL hdr_abort: got writes=%0d busy=%b err=%0d, required 0 0 0", wa_q.size(), busy, err_cnt - er0);
    end
    settle_and_clear();
  endtask

  // Scenario 6: asynchronous reset in PIX_LO after 10 pixels.
  task automatic test_reset_midframe();
    send_frame(8'hAB, 8'hCD, 8'h80);
    pulse_vsync();
    settle_and_clear();
    checks++;
    if (disp_bank !== 1'b1 || LED !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got bank=%b led=%b, required 1 1", disp_bank, LED);
    end
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_pixels(8'h12, 8'h34, 10);
    send_byte(8'h12);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ram_wren, ram_wraddr, ram_wrdata, disp_bank, busy, frame_ok, frame_err, LED} !== 27'd0) begin
      errors++;
      $display("FAIL rst_mid: got wren=%b addr=%h data=%h bank=%b busy=%b ok=%b err=%b led=%b, required all 0",
               ram_wren, ram_wraddr, ram_wrdata, disp_bank, busy, frame_ok, frame_err, LED);
    end
    @(negedge clk);
    rst = 1'b0;
    settle_and_clear();
    send_frame(8'h12, 8'h34, 8'h60);
    pulse_vsync();
    repeat (2) @(negedge clk);
    checks++;
    if (disp_bank !== 1'b1 || LED !== 1'b1 || count_bad(1'b1, 16'h1234) != 0) begin
      errors++;
      $display("FAIL rst_recover: got bank=%b led=%b writes=%0d, required 1 1 16", disp_bank, LED, wa_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_back_to_back();
    test_bad_checksum();
    test_timeout();
    test_header();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
